// File: rtl/imm_gen_pipe_pkg.sv
// Shared types and opcode constants for the registered immediate generator.
// Imported by the decoder, the pipeline top and the bus interface.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_SH   = 3'd2,
        IMM_S    = 3'd3,
        IMM_B    = 3'd4,
        IMM_U    = 3'd5,
        IMM_J    = 3'd6,
        IMM_Z    = 3'd7
    } imm_type_e;

    // Occupancy of the output register plus skid entry.
    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'd0,
        PIPE_ONE   = 2'd1,
        PIPE_TWO   = 2'd2
    } pipe_state_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    function automatic logic is_shift(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Fetch-side and consumer-side handshake bundle of the immediate generator.
// The pipeline stage uses the slave view; the upstream/downstream driver uses master.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    import imm_gen_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst_code;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  Imm_out;
    imm_type_e        imm_type;
    logic             illegal;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, inst_code, in_tag, out_ready,
        output in_ready, out_valid, Imm_out, imm_type, illegal, out_tag
    );

    modport master (
        output in_valid, inst_code, in_tag, out_ready,
        input  in_ready, out_valid, Imm_out, imm_type, illegal, out_tag
    );

endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Purely combinational RV32I/RV64I immediate decoder: classifies the opcode,
// flags illegal encodings and assembles the XLEN-wide immediate.
module imm_decode_comb
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);

    localparam bit IS_RV64 = (XLEN == 64);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        shamt_msb;
    logic [31:0] raw;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    // Only RV64 OP-IMM shifts use the sixth shamt bit; the *W shifts stay 5 bits wide.
    assign shamt_msb = IS_RV64 && (opcode == OPC_OPIMM) && inst[25];

    always_comb begin
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_MISC_MEM, OPC_JALR: imm_type = IMM_I;
            OPC_OPIMM: imm_type = is_shift(funct3) ? IMM_SH : IMM_I;
            OPC_OPIMM32: begin
                if (IS_RV64) begin
                    imm_type = is_shift(funct3) ? IMM_SH : IMM_I;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE:          imm_type = IMM_S;
            OPC_BRANCH:         imm_type = IMM_B;
            OPC_LUI, OPC_AUIPC: imm_type = IMM_U;
            OPC_JAL:            imm_type = IMM_J;
            OPC_SYSTEM: begin
                if (funct3[2]) begin
                    imm_type = IMM_Z;
                end
            end
            OPC_OP: begin
                illegal = 1'b0;
            end
            OPC_OP32: begin
                illegal = !IS_RV64;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Zero-extended forms keep raw[31] clear, so one sign extension serves every type.
    always_comb begin
        raw = 32'd0;
        case (imm_type)
            IMM_I:  raw = {{20{inst[31]}}, inst[31:20]};
            IMM_SH: raw = {26'd0, shamt_msb, inst[24:20]};
            IMM_S:  raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:  raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:  raw = {inst[31:12], 12'd0};
            IMM_J:  raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_Z:  raw = {27'd0, inst[19:15]};
            default: raw = 32'd0;
        endcase
    end

    always_comb begin
        imm       = {XLEN{raw[31]}};
        imm[31:0] = raw;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: one-cycle registered output with a single
// skid entry, valid/ready on both sides, branch-redirect flush and a sideband tag.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    imm_gen_pipe_if.slave bus
);

    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    pipe_state_e      state;
    pipe_state_e      state_n;
    logic             in_ready;
    logic             in_fire;
    logic             load_or;
    logic             or_from_sk;
    logic             load_sk;

    logic [XLEN-1:0]  dec_imm;
    imm_type_e        dec_type;
    logic             dec_illegal;

    logic [XLEN-1:0]  or_imm;
    imm_type_e        or_type;
    logic             or_illegal;
    logic [TAG_W-1:0] or_tag;

    logic [XLEN-1:0]  sk_imm;
    imm_type_e        sk_type;
    logic             sk_illegal;
    logic [TAG_W-1:0] sk_tag;

    imm_decode_comb #(
        .XLEN(XLEN)
    ) u_decode (
        .inst     (bus.inst_code),
        .imm      (dec_imm),
        .imm_type (dec_type),
        .illegal  (dec_illegal)
    );

    assign in_ready = (state != PIPE_TWO) && !flush_i;
    assign in_fire  = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PIPE_EMPTY;
        end else begin
            state <= state_n;
        end
    end

    // A stalled output register diverts the accepted entry into the skid slot;
    // a draining output register refills from the skid slot before new input.
    always_comb begin
        state_n    = state;
        load_or    = 1'b0;
        or_from_sk = 1'b0;
        load_sk    = 1'b0;
        if (flush_i) begin
            state_n = PIPE_EMPTY;
        end else begin
            case (state)
                PIPE_EMPTY: begin
                    if (in_fire) begin
                        load_or = 1'b1;
                        state_n = PIPE_ONE;
                    end
                end
                PIPE_ONE: begin
                    if (bus.out_ready) begin
                        if (in_fire) begin
                            load_or = 1'b1;
                        end else begin
                            state_n = PIPE_EMPTY;
                        end
                    end else if (in_fire) begin
                        load_sk = 1'b1;
                        state_n = PIPE_TWO;
                    end
                end
                PIPE_TWO: begin
                    if (bus.out_ready) begin
                        load_or    = 1'b1;
                        or_from_sk = 1'b1;
                        state_n    = PIPE_ONE;
                    end
                end
                default: state_n = PIPE_EMPTY;
            endcase
        end
    end

    // Payload only ever changes on a load, so it holds steady through stalls and flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_imm     <= '0;
            or_type    <= IMM_NONE;
            or_illegal <= 1'b0;
            or_tag     <= '0;
            sk_imm     <= '0;
            sk_type    <= IMM_NONE;
            sk_illegal <= 1'b0;
            sk_tag     <= '0;
        end else begin
            if (load_or) begin
                if (or_from_sk) begin
                    or_imm     <= sk_imm;
                    or_type    <= sk_type;
                    or_illegal <= sk_illegal;
                    or_tag     <= sk_tag;
                end else begin
                    or_imm     <= dec_imm;
                    or_type    <= dec_type;
                    or_illegal <= dec_illegal;
                    or_tag     <= bus.in_tag;
                end
            end
            if (load_sk) begin
                sk_imm     <= dec_imm;
                sk_type    <= dec_type;
                sk_illegal <= dec_illegal;
                sk_tag     <= bus.in_tag;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state != PIPE_EMPTY);
    assign bus.Imm_out   = or_imm;
    assign bus.imm_type  = or_type;
    assign bus.illegal   = or_illegal;
    assign bus.out_tag   = or_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN32 and XLEN64 instances share one input stream;
// covers decode vectors, random backpressure ordering, flush and asynchronous reset.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] inst_code = 32'd0;
    logic [31:0] in_tag = 32'd0;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

    assign bus32.in_valid  = in_valid;
    assign bus32.inst_code = inst_code;
    assign bus32.in_tag    = in_tag;
    assign bus32.out_ready = out_ready;
    assign bus64.in_valid  = in_valid;
    assign bus64.inst_code = inst_code;
    assign bus64.in_tag    = in_tag;
    assign bus64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .bus     (bus32.slave)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .bus     (bus64.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] code;
        logic [63:0] imm32;
        logic [63:0] imm64;
        imm_type_e   t32;
        imm_type_e   t64;
        logic        ill32;
        logic        ill64;
    } vec_t;

    vec_t vecs[$];

    task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [31:0] code, input logic [31:0] tag);
        in_valid  = valid;
        inst_code = code;
        in_tag    = tag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi_code(input int v);
        return {v[11:0], 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    initial begin
        int sent;
        int rcv;
        logic stalled_prev;
        logic [31:0] saved_tag;
        logic [63:0] saved_imm;
        logic fire_in;
        logic fire_out;

        vecs.push_back('{32'hFFF00093, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, IMM_I, IMM_I, 1'b0, 1'b0});
        vecs.push_back('{32'h800000B7, 64'h80000000, 64'hFFFFFFFF80000000, IMM_U, IMM_U, 1'b0, 1'b0});
        vecs.push_back('{32'h43F0D093, 64'h1F, 64'h3F, IMM_SH, IMM_SH, 1'b0, 1'b0});
        vecs.push_back('{32'hFE000EE3, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, IMM_B, IMM_B, 1'b0, 1'b0});
        vecs.push_back('{32'h300FD073, 64'h1F, 64'h1F, IMM_Z, IMM_Z, 1'b0, 1'b0});
        vecs.push_back('{32'h00000000, 64'h0, 64'h0, IMM_NONE, IMM_NONE, 1'b1, 1'b1});
        vecs.push_back('{32'hFE112E23, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, IMM_S, IMM_S, 1'b0, 1'b0});
        vecs.push_back('{32'h008000EF, 64'h8, 64'h8, IMM_J, IMM_J, 1'b0, 1'b0});
        vecs.push_back('{32'h0010809B, 64'h0, 64'h1, IMM_NONE, IMM_I, 1'b1, 1'b0});
        vecs.push_back('{32'h0000003B, 64'h0, 64'h0, IMM_NONE, IMM_NONE, 1'b1, 1'b0});
        vecs.push_back('{32'h00000033, 64'h0, 64'h0, IMM_NONE, IMM_NONE, 1'b0, 1'b0});

        // Reset values
        #12;
        check_output("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        check_output("rst_imm", 64'(bus64.Imm_out), 64'd0);
        check_output("rst_type", 64'(bus32.imm_type), 64'(IMM_NONE));
        check_output("rst_illegal", 64'(bus32.illegal), 64'd0);
        check_output("rst_tag", 64'(bus32.out_tag), 64'd0);
        rst_n = 1'b1;
        tick();
        check_output("rst_in_ready", 64'(bus32.in_ready), 64'd1);

        // Decode vectors streamed at full rate
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            apply_stimulus(1'b1, vecs[i].code, 32'h100 + i);
            tick();
            check_output($sformatf("v%0d_valid32", i), 64'(bus32.out_valid), 64'd1);
            check_output($sformatf("v%0d_imm32", i), 64'(bus32.Imm_out), vecs[i].imm32);
            check_output($sformatf("v%0d_type32", i), 64'(bus32.imm_type), 64'(vecs[i].t32));
            check_output($sformatf("v%0d_ill32", i), 64'(bus32.illegal), 64'(vecs[i].ill32));
            check_output($sformatf("v%0d_tag32", i), 64'(bus32.out_tag), 64'(32'h100 + i));
            check_output($sformatf("v%0d_imm64", i), 64'(bus64.Imm_out), vecs[i].imm64);
            check_output($sformatf("v%0d_type64", i), 64'(bus64.imm_type), 64'(vecs[i].t64));
            check_output($sformatf("v%0d_ill64", i), 64'(bus64.illegal), 64'(vecs[i].ill64));
        end
        apply_stimulus(1'b0, 32'd0, 32'd0);
        tick();
        check_output("drain_valid", 64'(bus32.out_valid), 64'd0);

        // Tags 1..8 under random backpressure; expected order and occupancy from counters
        sent = 0;
        rcv = 0;
        stalled_prev = 1'b0;
        saved_tag = '0;
        saved_imm = '0;
        for (int cyc = 0; cyc < 300 && rcv < 8; cyc++) begin
            if (sent < 8) apply_stimulus(1'b1, addi_code(sent + 1), 32'(sent + 1));
            else apply_stimulus(1'b0, 32'd0, 32'd0);
            out_ready = (cyc < 3) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            check_output("bp_in_ready", 64'(bus32.in_ready), 64'((sent - rcv) < 2));
            check_output("bp_out_valid", 64'(bus32.out_valid), 64'((sent - rcv) > 0));
            if (stalled_prev) begin
                check_output("bp_stable_tag", 64'(bus32.out_tag), 64'(saved_tag));
                check_output("bp_stable_imm", 64'(bus32.Imm_out), saved_imm);
            end
            if (bus32.out_valid) begin
                check_output("bp_order_tag", 64'(bus32.out_tag), 64'(rcv + 1));
                check_output("bp_order_imm", 64'(bus32.Imm_out), 64'(rcv + 1));
            end
            fire_out = bus32.out_valid && out_ready;
            fire_in  = in_valid && bus32.in_ready;
            stalled_prev = bus32.out_valid && !out_ready;
            saved_tag = bus32.out_tag;
            saved_imm = 64'(bus32.Imm_out);
            if (fire_out) rcv++;
            if (fire_in) sent++;
            tick();
        end
        check_output("bp_all_received", 64'(rcv), 64'd8);
        check_output("bp_all_sent", 64'(sent), 64'd8);

        // Flush with both entries held and a competing input
        apply_stimulus(1'b0, 32'd0, 32'd0);
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        apply_stimulus(1'b1, addi_code(10), 32'h41);
        tick();
        apply_stimulus(1'b1, addi_code(11), 32'h42);
        tick();
        check_output("fl_full_in_ready", 64'(bus32.in_ready), 64'd0);
        check_output("fl_full_head", 64'(bus32.out_tag), 64'h41);
        apply_stimulus(1'b1, addi_code(12), 32'h43);
        flush = 1'b1;
        #1;
        check_output("fl_in_ready", 64'(bus32.in_ready), 64'd0);
        tick();
        flush = 1'b0;
        check_output("fl_out_valid", 64'(bus32.out_valid), 64'd0);
        check_output("fl_payload_kept", 64'(bus32.out_tag), 64'h41);
        apply_stimulus(1'b1, addi_code(13), 32'h44);
        out_ready = 1'b1;
        #1;
        check_output("fl_reopen", 64'(bus32.in_ready), 64'd1);
        tick();
        apply_stimulus(1'b0, 32'd0, 32'd0);
        check_output("fl_next_tag", 64'(bus32.out_tag), 64'h44);
        check_output("fl_next_imm", 64'(bus32.Imm_out), 64'd13);
        tick();
        check_output("fl_alone", 64'(bus32.out_valid), 64'd0);

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        apply_stimulus(1'b1, 32'hFFF00093, 32'h51);
        tick();
        apply_stimulus(1'b1, 32'h800000B7, 32'h52);
        tick();
        apply_stimulus(1'b0, 32'd0, 32'd0);
        check_output("ar_pre_valid", 64'(bus32.out_valid), 64'd1);
        check_output("ar_pre_in_ready", 64'(bus32.in_ready), 64'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("ar_out_valid", 64'(bus32.out_valid), 64'd0);
        check_output("ar_imm32", 64'(bus32.Imm_out), 64'd0);
        check_output("ar_imm64", 64'(bus64.Imm_out), 64'd0);
        check_output("ar_type", 64'(bus32.imm_type), 64'(IMM_NONE));
        check_output("ar_tag", 64'(bus64.out_tag), 64'd0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        check_output("ar_in_ready", 64'(bus32.in_ready), 64'd1);
        check_output("ar_post_valid", 64'(bus64.out_valid), 64'd0);
        out_ready = 1'b1;
        apply_stimulus(1'b1, addi_code(5), 32'h60);
        tick();
        apply_stimulus(1'b0, 32'd0, 32'd0);
        check_output("ar_alive_tag", 64'(bus32.out_tag), 64'h60);
        check_output("ar_alive_imm", 64'(bus64.Imm_out), 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
